// File: rtl/insseq_pkg.sv
// insseq_pkg: shared state encodings, halt code and default widths for the micro-sequencer
package insseq_pkg;
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;
  localparam logic [2:0] IB_HALT = 3'd0;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
endpackage

// File: rtl/insseq_if.sv
// insseq_if: opcode-fetch memory read bus with req/ack handshake
interface insseq_if #(parameter int AW = 8, parameter int DW = 8);
  logic          mem_rd_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_rd_ack;
  modport master (output mem_rd_req, mem_addr, input mem_rdata, mem_rd_ack);
  modport slave  (input mem_rd_req, mem_addr, output mem_rdata, mem_rd_ack);
endinterface

// File: rtl/insseq_pc.sv
// insseq_pc: program counter with load-over-increment priority and modulo-2^AW wrap
module insseq_pc #(parameter int AW = 8) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  input  logic [AW-1:0] pc_in,
  output logic [AW-1:0] pc
);
  logic [AW-1:0] pc_d, pc_q;
  always_comb pc_d = load ? pc_in : inc ? pc_q + 1'b1 : pc_q;
  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end
  assign pc = pc_q;
endmodule

// File: rtl/insseq.sv
// insseq: opcode fetch and execute micro-step sequencer feeding the instruction decoder
module insseq
  import insseq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  insseq_if.master      mem,
  output logic [7:0]    ird,
  input  logic [2:0]    ib,
  input  logic [2:0]    sb,
  input  logic          stall,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_in,
  output logic          exec_en,
  output logic [2:0]    ustep,
  output logic          last_step,
  output logic          halted,
  output logic [AW-1:0] pc
);
  state_t     state_d, state_q;
  logic [2:0] cnt_d, cnt_q, step_d, step_q;
  logic [7:0] ird_d, ird_q;
  logic       fetch_ack, go_exec, run, run_step;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      step_q  <= '0;
      ird_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      ird_q   <= ird_d;
    end
  end
  always_comb begin
    fetch_ack = state_q == FETCH && mem.mem_rd_ack;
    go_exec   = state_q == DECODE && ib != IB_HALT;
    run       = state_q == EXEC && !stall;
    run_step  = run && cnt_q != 3'd1;
    state_d   = fetch_ack ? DECODE :
                state_q == DECODE ? (go_exec ? EXEC : HALT) :
                run && cnt_q == 3'd1 ? FETCH : state_q;
    cnt_d     = go_exec ? ib : run_step ? cnt_q - 3'd1 : cnt_q;
    step_d    = go_exec ? sb : run_step ? step_q + 3'd1 : step_q;
    ird_d     = fetch_ack ? mem.mem_rdata : ird_q;
  end
  // request is masked during reset so a pending fetch drops immediately
  always_comb begin
    mem.mem_rd_req = state_q == FETCH && !reset;
    mem.mem_addr   = pc;
    exec_en        = state_q == EXEC;
    ustep          = step_q;
    last_step      = state_q == EXEC && cnt_q == 3'd1;
    halted         = state_q == HALT;
    ird            = ird_q;
  end
  insseq_pc #(.AW(AW)) u_pc (
    .clk   (clk),
    .reset (reset),
    .inc   (fetch_ack),
    .load  (run && pc_load),
    .pc_in (pc_in),
    .pc    (pc)
  );
endmodule

// File: tb/tb_insseq.sv
// tb_insseq: directed instruction sequences with a queued scoreboard of fetch and execute events
module tb_insseq;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ird, pc, pc_in;
  logic [2:0] ib, sb, ustep;
  logic       stall, pc_load, exec_en, last_step, halted;

  insseq_if #(.AW(8), .DW(8)) mem ();

  insseq #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (mem),
    .ird       (ird),
    .ib        (ib),
    .sb        (sb),
    .stall     (stall),
    .pc_load   (pc_load),
    .pc_in     (pc_in),
    .exec_en   (exec_en),
    .ustep     (ustep),
    .last_step (last_step),
    .halted    (halted),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  always_comb begin
    {ib, sb} = {3'd1, 3'd0};
    case (ird)
      8'hC0: {ib, sb} = {3'd1, 3'd2};
      8'h08: {ib, sb} = {3'd6, 3'd5};
      8'h0C: {ib, sb} = {3'd3, 3'd5};
      8'h00: {ib, sb} = {3'd0, 3'd0};
      8'h11: {ib, sb} = {3'd2, 3'd0};
      8'h22: {ib, sb} = {3'd2, 3'd3};
      default: {ib, sb} = {3'd1, 3'd0};
    endcase
  end

  typedef struct packed {
    logic       is_exec;
    logic [7:0] val;
    logic       last;
  } exp_t;

  exp_t q[$];
  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input logic is_exec, input logic [7:0] val, input logic last);
    exp_t e;
    if (q.size() == 0) begin
      vecs++;
      errs++;
      $display("FAIL unexpected_event: got kind %0d val %0h with empty queue", is_exec, val);
    end else begin
      e = q.pop_front();
      chk("event_kind", {31'd0, is_exec}, {31'd0, e.is_exec});
      chk(is_exec ? "ustep" : "fetch_addr", {24'd0, val}, {24'd0, e.val});
      if (is_exec) chk("last_step", {31'd0, last}, {31'd0, e.last});
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem.mem_rd_req && mem.mem_rd_ack) pop_chk(1'b0, mem.mem_addr, 1'b0);
      if (exec_en) pop_chk(1'b1, {5'd0, ustep}, last_step);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] op, input int dly, input int n, input logic [2:0] sb0,
                           input int st_at, input int st_len, input int ld_at, input logic ld_stall,
                           input logic [7:0] ld_val);
    logic [7:0] prev_ird;
    logic [2:0] step;
    prev_ird = ird;
    q.push_back('{1'b0, exp_pc, 1'b0});
    for (int i = 0; i < dly; i++) begin
      chk("req_held", {31'd0, mem.mem_rd_req}, 32'd1);
      chk("addr_stable", {24'd0, mem.mem_addr}, {24'd0, exp_pc});
      chk("ird_hold", {24'd0, ird}, {24'd0, prev_ird});
      tick();
    end
    chk("req_at_ack", {31'd0, mem.mem_rd_req}, 32'd1);
    mem.mem_rdata = op;
    mem.mem_rd_ack = 1'b1;
    tick();
    mem.mem_rd_ack = 1'b0;
    exp_pc = exp_pc + 8'd1;
    chk("ird_latch", {24'd0, ird}, {24'd0, op});
    chk("pc_inc", {24'd0, pc}, {24'd0, exp_pc});
    tick();
    if (n == 0) begin
      chk("halt_enter", {31'd0, halted}, 32'd1);
      return;
    end
    step = sb0;
    for (int k = 0; k < n; k++) begin
      if (k == st_at) begin
        for (int s = 0; s < st_len; s++) begin
          stall = 1'b1;
          pc_load = (k == ld_at) && ld_stall;
          pc_in = ld_val;
          q.push_back('{1'b1, {5'd0, step}, k == n - 1});
          tick();
        end
      end
      stall = 1'b0;
      pc_load = (k == ld_at) && !ld_stall;
      pc_in = ld_val;
      if (pc_load) exp_pc = ld_val;
      q.push_back('{1'b1, {5'd0, step}, k == n - 1});
      tick();
      step = step + 3'd1;
    end
    stall = 1'b0;
    pc_load = 1'b0;
    chk("next_fetch_req", {31'd0, mem.mem_rd_req}, 32'd1);
    chk("next_fetch_addr", {24'd0, mem.mem_addr}, {24'd0, exp_pc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    pc_load = 1'b0;
    pc_in = '0;
    mem.mem_rd_ack = 1'b0;
    mem.mem_rdata = '0;
    repeat (2) tick();
    chk("rst_req", {31'd0, mem.mem_rd_req}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_ird", {24'd0, ird}, 32'd0);
    chk("rst_exec_en", {31'd0, exec_en}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_last", {31'd0, last_step}, 32'd0);
    chk("rst_ustep", {29'd0, ustep}, 32'd0);
    reset = 1'b0;
    #1;
    chk("first_req", {31'd0, mem.mem_rd_req}, 32'd1);
    chk("first_addr", {24'd0, mem.mem_addr}, 32'd0);
    exp_pc = 8'h00;
    run_instr(8'hC0, 0, 1, 3'd2, -1, 0, -1, 1'b0, 8'h00);
    run_instr(8'h08, 0, 6, 3'd5, -1, 0, -1, 1'b0, 8'h00);
    run_instr(8'h11, 3, 2, 3'd0, -1, 0, -1, 1'b0, 8'h00);
    run_instr(8'h0C, 0, 3, 3'd5, 1, 2, -1, 1'b0, 8'h00);
    run_instr(8'h22, 0, 2, 3'd3, -1, 0, 0, 1'b0, 8'h40);
    run_instr(8'h22, 0, 2, 3'd3, 0, 1, 0, 1'b1, 8'h80);
    repeat (2) tick();
    mem.mem_rdata = 8'hC0;
    mem.mem_rd_ack = 1'b1;
    reset = 1'b1;
    tick();
    mem.mem_rd_ack = 1'b0;
    chk("midfetch_rst_req", {31'd0, mem.mem_rd_req}, 32'd0);
    chk("midfetch_rst_pc", {24'd0, pc}, 32'd0);
    chk("midfetch_rst_ird", {24'd0, ird}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_req", {31'd0, mem.mem_rd_req}, 32'd1);
    exp_pc = 8'h00;
    run_instr(8'h22, 0, 2, 3'd3, -1, 0, 1, 1'b0, 8'hFF);
    run_instr(8'hC0, 0, 1, 3'd2, -1, 0, -1, 1'b0, 8'h00);
    run_instr(8'h00, 0, 0, 3'd0, -1, 0, -1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      pc_load = 1'b1;
      pc_in = 8'h55;
      chk("halt_state", {30'd0, halted, mem.mem_rd_req}, 32'd2);
      tick();
    end
    pc_load = 1'b0;
    chk("halt_pc_hold", {24'd0, pc}, 32'd1);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
